// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder. One full-adder cell and a carry flop
//             add two WIDTH-bit operands plus carry-in LSB-first, one bit per
//             clock, then present the registered sum/carry-out with a
//             one-cycle done pulse.
//  Ports    : clk    - system clock, rising-edge active
//             rst_n  - asynchronous active-low reset
//             start  - add request, accepted only while idle
//             a, b   - WIDTH-bit operands, captured on accepted start
//             cin    - carry-in, captured on accepted start
//             busy   - high from the edge after acceptance through done
//             done   - one-cycle pulse, sum/cout valid from this cycle
//             sum    - registered WIDTH-bit result
//             cout   - registered carry-out
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_s;
    logic w_c;

    // The single full-adder cell, always looking at the current LSBs.
    always_comb begin
        w_s = r_a[0] ^ r_b[0] ^ r_carry;
        w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0
                    // has travelled down to the LSB.
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_bit) begin
                        // Publish including the bit being produced now.
                        sum     <= {w_s, r_acc[WIDTH-1:1]};
                        cout    <= w_c;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       cin3 = 1'b0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(W3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
        int         pulse_at;
    } vec_t;

    // One add on the WIDTH=8 instance. Operands are scrambled right after the
    // accepting edge; an optional extra start pulse is issued at negedge
    // index pulse_at (k=0 is the first SHIFT cycle).
    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input int pulse_at,
                        output logic [7:0] s, output logic co, output int lat,
                        output int nbusy, output int ndone, output int nearly);
        logic [7:0] prev_sum;
        logic       prev_cout;
        @(negedge clk);
        prev_sum  = sum8;
        prev_cout = cout8;
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = -1; s = 'x; co = 1'bx; nbusy = 0; ndone = 0; nearly = 0;
        for (int k = 0; k < W8 + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == pulse_at) begin
                start8 = 1'b1; a8 = 8'h7f; b8 = 8'h7f;
            end else begin
                start8 = 1'b0;
            end
            if (busy8) nbusy++;
            if (done8) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; s = sum8; co = cout8;
                end
            end else if (lat < 0 && (sum8 !== prev_sum || cout8 !== prev_cout)) begin
                nearly++;
            end
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        logic [7:0] s;
        logic       co;
        int lat, nb, nd, ne;
        add8(v.a, v.b, v.cin, v.pulse_at, s, co, lat, nb, nd, ne);
        check({name, "_sum"},     64'(s),   64'(v.esum));
        check({name, "_cout"},    64'(co),  64'(v.ecout));
        check({name, "_latency"}, 64'(lat), 64'(W8));
        check({name, "_busy"},    64'(nb),  64'(W8 + 1));
        check({name, "_ndone"},   64'(nd),  64'(1));
        check({name, "_held"},    64'(ne),  64'(0));
    endtask

    // Reference: per-bit full-adder truth table done with integer arithmetic.
    function automatic logic [3:0] ripple3(input logic [2:0] x, input logic [2:0] y, input logic c);
        logic [3:0] r;
        int cc;
        int t;
        cc = int'(c);
        r = '0;
        for (int i = 0; i < 3; i++) begin
            t = int'(x[i]) + int'(y[i]) + cc;
            r[i] = (t % 2) == 1;
            cc = t / 2;
        end
        r[3] = (cc == 1);
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        vec_t rv;
        int   q[$];
        int   idx, ndone3, nd, k;
        int   dtimes[$];
        logic [6:0] ev;
        logic [8:0] tot;

        // ---------------- reset state ----------------
        #1;
        check("rst_busy8", 64'(busy8), 64'(0));
        check("rst_done8", 64'(done8), 64'(0));
        check("rst_sum8",  64'({cout8, sum8}), 64'(0));
        check("rst_out3",  64'({busy3, done3, cout3, sum3}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, -1};
        vecs[1] = '{8'hff, 8'h01, 1'b0, 8'h00, 1'b1, -1};
        vecs[2] = '{8'hff, 8'hff, 1'b1, 8'hff, 1'b1, -1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1};
        vecs[5] = '{8'h7f, 8'h00, 1'b1, 8'h80, 1'b0, -1};
        // start pulse during the third SHIFT cycle must be ignored
        vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 2};
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- randomized vs arithmetic model ----------------
        for (int i = 0; i < 12; i++) begin
            rv.a = 8'($urandom);
            rv.b = 8'($urandom);
            rv.cin = 1'($urandom);
            tot = 9'(rv.a) + 9'(rv.b) + 9'(rv.cin);
            rv.esum = tot[7:0];
            rv.ecout = tot[8];
            rv.pulse_at = -1;
            apply($sformatf("rnd%0d", i), rv);
        end

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        a8 = 8'haa; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'(0));
        check("midrst_done", 64'(done8), 64'(0));
        check("midrst_out",  64'({cout8, sum8}), 64'(0));
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("midrst_nodone", 64'(nd), 64'(0));
        rst_n = 1'b1;
        vecs[0] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1};
        apply("after_rst", vecs[0]);

        // ---------------- held start ----------------
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        for (k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done8) begin
                dtimes.push_back(k);
                check("held_sum", 64'({cout8, sum8}), 64'(9'h003));
            end
            if (dtimes.size() == 3) start8 = 1'b0;
        end
        start8 = 1'b0;
        check("held_ndone", 64'(dtimes.size()), 64'(3));
        if (dtimes.size() == 3) begin
            check("held_gap1", 64'(dtimes[1] - dtimes[0]), 64'(W8 + 2));
            check("held_gap2", 64'(dtimes[2] - dtimes[1]), 64'(W8 + 2));
        end

        // ---------------- exhaustive WIDTH=3, back-to-back ----------------
        idx = 0;
        ndone3 = 0;
        for (int cyc = 0; cyc < 128 * (W3 + 2) + 40 && ndone3 < 128; cyc++) begin
            @(negedge clk);
            if (done3) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL exh_spurious_done actual=1 expected=0");
                end else begin
                    ev = 7'(q.pop_front());
                    check($sformatf("exh_ripple_%0d", ev), 64'({cout3, sum3}),
                          64'(ripple3(ev[2:0], ev[5:3], ev[6])));
                    check($sformatf("exh_int_%0d", ev), 64'({cout3, sum3}),
                          64'(int'(ev[2:0]) + int'(ev[5:3]) + int'(ev[6])));
                end
                ndone3++;
            end
            if (!busy3) begin
                if (idx < 128) begin
                    {cin3, b3, a3} = 7'(idx);
                    q.push_back(idx);
                    idx++;
                    start3 = 1'b1;
                end else begin
                    start3 = 1'b0;
                end
            end
        end
        start3 = 1'b0;
        check("exh_done_count", 64'(ndone3), 64'(128));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
